// File: rtl/block_pkg.sv
// Shared constants and elaboration-time helpers for the block grid.
package block_pkg;

  localparam int BLOCK_COLS = 13;
  localparam int BLOCK_ROWS = 16;
  localparam int POP_MAX    = 4096;

  // Even rows carry 8 blocks and odd rows carry 5, so the default level has 104 blocks.
  localparam logic [12:0] ROW_EVEN = 13'b0101010101111;
  localparam logic [12:0] ROW_ODD  = 13'b1010101000001;

  localparam logic [BLOCK_ROWS*BLOCK_COLS-1:0] BLOCK_INIT_DEFAULT = {8{ROW_ODD, ROW_EVEN}};

  function automatic int clog2(input int value);
    int r = 0;
    int v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int popcount(input logic [POP_MAX-1:0] v);
    int n = 0;
    for (int i = 0; i < POP_MAX; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/block_grid.sv
// Breakout-style block field: row-pointer scan out, single-cycle hit/clear with
// registered response, live block count and level reload.
module block_grid
  import block_pkg::*;
#(
  parameter int COLS = BLOCK_COLS,
  parameter int ROWS = BLOCK_ROWS,
  parameter logic [ROWS*COLS-1:0] INIT = BLOCK_INIT_DEFAULT
) (
  input  logic                              clk,
  input  logic                              nRst,
  input  logic                              line_start,
  input  logic                              next_line,
  output logic [COLS-1:0]                   line,
  output logic [clog2(ROWS)-1:0]            row_idx,
  input  logic                              hit_valid,
  input  logic [clog2(ROWS)-1:0]            hit_row,
  input  logic [clog2(COLS)-1:0]            hit_col,
  output logic                              hit_done,
  output logic                              hit_was_set,
  input  logic                              reload,
  output logic [clog2(ROWS*COLS+1)-1:0]     remaining,
  output logic                              cleared
);

  localparam int RW         = clog2(ROWS);
  localparam int CW         = clog2(ROWS * COLS + 1);
  localparam int INIT_COUNT = popcount(POP_MAX'(INIT));

  logic [COLS-1:0] grid [ROWS];
  logic [RW-1:0]   row_ptr;
  logic            coord_ok;
  logic            hit_ok;

  // A hit only counts when it lands on a live block and no reload overrides it.
  always_comb begin
    coord_ok = (int'(hit_row) < ROWS) && (int'(hit_col) < COLS);
    hit_ok   = 1'b0;
    if (hit_valid && coord_ok && !reload) hit_ok = grid[hit_row][hit_col];
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int r = 0; r < ROWS; r++) grid[r] <= INIT[r*COLS +: COLS];
      row_ptr     <= '0;
      remaining   <= CW'(INIT_COUNT);
      hit_done    <= 1'b0;
      hit_was_set <= 1'b0;
    end else begin
      hit_done    <= hit_valid;
      hit_was_set <= hit_ok;
      if (reload) begin
        for (int r = 0; r < ROWS; r++) grid[r] <= INIT[r*COLS +: COLS];
        row_ptr   <= '0;
        remaining <= CW'(INIT_COUNT);
      end else begin
        if (hit_ok) begin
          grid[hit_row][hit_col] <= 1'b0;
          if (remaining != '0) remaining <= remaining - 1'b1;
        end
        if (line_start) begin
          row_ptr <= '0;
        end else if (next_line) begin
          row_ptr <= (row_ptr == RW'(ROWS - 1)) ? '0 : row_ptr + 1'b1;
        end
      end
    end
  end

  assign line    = grid[row_ptr];
  assign row_idx = row_ptr;
  assign cleared = (remaining == '0);

endmodule

// File: tb/tb_block_grid.sv
// Bench for block_grid: directed scenarios plus randomized traffic against a grid model.
module tb_block_grid;

  localparam int COLS = 13;
  localparam int ROWS = 16;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        line_start = 1'b0;
  logic        next_line = 1'b0;
  logic        hit_valid = 1'b0;
  logic        reload = 1'b0;
  logic [3:0]  hit_row = '0;
  logic [3:0]  hit_col = '0;
  logic [12:0] line;
  logic [3:0]  row_idx;
  logic        hit_done;
  logic        hit_was_set;
  logic [7:0]  remaining;
  logic        cleared;

  int vectors = 0;
  int miscompares = 0;

  logic [12:0] m_grid [ROWS];
  int          m_row;
  int          m_rem;
  logic        exp_done;
  logic        exp_set;
  logic [0:0]  exp_q [$];

  block_grid dut (
    .clk(clk), .nRst(nRst), .line_start(line_start), .next_line(next_line),
    .line(line), .row_idx(row_idx), .hit_valid(hit_valid), .hit_row(hit_row),
    .hit_col(hit_col), .hit_done(hit_done), .hit_was_set(hit_was_set),
    .reload(reload), .remaining(remaining), .cleared(cleared)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] init_row(input int r);
    return (r % 2 == 0) ? 13'b0101010101111 : 13'b1010101000001;
  endfunction

  task automatic model_init();
    m_rem = 0;
    for (int r = 0; r < ROWS; r++) begin
      m_grid[r] = init_row(r);
      for (int c = 0; c < COLS; c++) if (m_grid[r][c]) m_rem++;
    end
    m_row = 0;
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic apply(input bit ls, input bit nl, input bit hv, input int hr, input int hc, input bit rl);
    line_start = ls;
    next_line  = nl;
    hit_valid  = hv;
    hit_row    = 4'(hr);
    hit_col    = 4'(hc);
    reload     = rl;
    exp_done   = hv;
    exp_set    = 1'b0;
    if (rl) begin
      model_init();
    end else begin
      if (hv && hr < ROWS && hc < COLS) begin
        if (m_grid[hr][hc]) begin
          exp_set = 1'b1;
          m_grid[hr][hc] = 1'b0;
          m_rem--;
        end
      end
      if (ls) m_row = 0;
      else if (nl) m_row = (m_row + 1) % ROWS;
    end
    @(posedge clk);
    #1;
    line_start = 1'b0;
    next_line  = 1'b0;
    hit_valid  = 1'b0;
    reload     = 1'b0;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    model_init();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (remaining !== 8'd104 || m_rem != 104) begin
      miscompares++;
      $display("FAIL reset_remaining: got %0d want 104", remaining);
    end
    vectors++;
    if (row_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_row_idx: got %0d want 0", row_idx);
    end
    vectors++;
    if (line !== 13'b0101010101111) begin
      miscompares++;
      $display("FAIL reset_line: got %b want 0101010101111", line);
    end
    vectors++;
    if (cleared !== 1'b0 || hit_done !== 1'b0 || hit_was_set !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got cleared=%b done=%b set=%b want 0 0 0", cleared, hit_done, hit_was_set);
    end
    nRst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_hit_basic();
    apply(0, 0, 1, 0, 0, 0);
    vectors++;
    if (hit_done !== 1'b1 || hit_was_set !== 1'b1) begin
      miscompares++;
      $display("FAIL hit_first_resp: got done=%b set=%b want 1 1", hit_done, hit_was_set);
    end
    vectors++;
    if (remaining !== 8'd103 || line[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_first_state: got rem=%0d line0=%b want 103 0", remaining, line[0]);
    end
    apply(0, 0, 0, 0, 0, 0);
    vectors++;
    if (hit_done !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_done_pulse: got %b want 0", hit_done);
    end
    apply(0, 0, 1, 0, 0, 0);
    vectors++;
    if (hit_done !== 1'b1 || hit_was_set !== 1'b0 || remaining !== 8'd103) begin
      miscompares++;
      $display("FAIL hit_repeat: got done=%b set=%b rem=%0d want 1 0 103", hit_done, hit_was_set, remaining);
    end
  endtask

  task automatic test_scan();
    for (int i = 1; i <= 16; i++) begin
      apply(0, 1, 0, 0, 0, 0);
      vectors++;
      if (row_idx !== 4'(i % 16) || line !== m_grid[i % 16]) begin
        miscompares++;
        $display("FAIL scan_step%0d: got row=%0d line=%b want row=%0d line=%b", i, row_idx, line, i % 16, m_grid[i % 16]);
      end
    end
    for (int i = 0; i < 7; i++) apply(0, 1, 0, 0, 0, 0);
    vectors++;
    if (row_idx !== 4'd7) begin
      miscompares++;
      $display("FAIL scan_row7: got %0d want 7", row_idx);
    end
    apply(1, 1, 0, 0, 0, 0);
    vectors++;
    if (row_idx !== 4'd0 || line !== m_grid[0]) begin
      miscompares++;
      $display("FAIL scan_line_start_wins: got row=%0d want 0", row_idx);
    end
  endtask

  task automatic test_out_of_range();
    int rem_before;
    rem_before = m_rem;
    for (int k = 0; k < 6; k++) begin
      apply(0, 0, 1, $urandom_range(0, 15), $urandom_range(13, 15), 0);
      vectors++;
      if (hit_done !== 1'b1 || hit_was_set !== 1'b0 || remaining !== 8'(rem_before)) begin
        miscompares++;
        $display("FAIL oor_hit%0d: got done=%b set=%b rem=%0d want 1 0 %0d", k, hit_done, hit_was_set, remaining, rem_before);
      end
    end
  endtask

  task automatic test_random();
    bit ls, nl, hv, rl;
    for (int k = 0; k < 400; k++) begin
      ls = ($urandom_range(0, 9) == 0);
      nl = ($urandom_range(0, 2) == 0);
      hv = ($urandom_range(0, 1) == 1);
      rl = ($urandom_range(0, 49) == 0);
      apply(ls, nl, hv, $urandom_range(0, 15), $urandom_range(0, 15), rl);
      if (exp_done) exp_q.push_back(exp_set);
      vectors++;
      if (row_idx !== 4'(m_row) || line !== m_grid[m_row]) begin
        miscompares++;
        $display("FAIL rand_scan%0d: got row=%0d line=%b want row=%0d line=%b", k, row_idx, line, m_row, m_grid[m_row]);
      end
      vectors++;
      if (remaining !== 8'(m_rem) || cleared !== (m_rem == 0)) begin
        miscompares++;
        $display("FAIL rand_count%0d: got rem=%0d clr=%b want %0d", k, remaining, cleared, m_rem);
      end
      vectors++;
      if (hit_done !== exp_done) begin
        miscompares++;
        $display("FAIL rand_done%0d: got %b want %b", k, hit_done, exp_done);
      end
      if (hit_done === 1'b1 && exp_q.size() > 0) begin
        logic [0:0] want;
        want = exp_q.pop_front();
        vectors++;
        if (hit_was_set !== want[0]) begin
          miscompares++;
          $display("FAIL rand_set%0d: got %b want %b", k, hit_was_set, want[0]);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_queue: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_clear_all();
    int sets;
    apply(0, 0, 0, 0, 0, 1);
    sets = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (m_grid[r][c]) begin
          apply(0, $urandom_range(0, 1), 1, r, c, 0);
          if (hit_was_set === 1'b1) sets++;
        end
      end
    end
    vectors++;
    if (sets != 104) begin
      miscompares++;
      $display("FAIL clear_set_count: got %0d want 104", sets);
    end
    vectors++;
    if (remaining !== 8'd0 || cleared !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_done: got rem=%0d clr=%b want 0 1", remaining, cleared);
    end
    for (int k = 0; k < 5; k++) begin
      apply(0, 0, 1, $urandom_range(0, 15), $urandom_range(0, 12), 0);
      vectors++;
      if (remaining !== 8'd0 || hit_was_set !== 1'b0 || cleared !== 1'b1) begin
        miscompares++;
        $display("FAIL clear_extra%0d: got rem=%0d set=%b want 0 0", k, remaining, hit_was_set);
      end
    end
    apply(0, 1, 0, 0, 0, 1);
    vectors++;
    if (remaining !== 8'd104 || cleared !== 1'b0 || row_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL clear_reload: got rem=%0d clr=%b row=%0d want 104 0 0", remaining, cleared, row_idx);
    end
  endtask

  task automatic test_reload_hit();
    apply(0, 0, 1, 0, 0, 1);
    vectors++;
    if (hit_done !== 1'b1 || hit_was_set !== 1'b0 || remaining !== 8'd104 || line[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL reload_hit: got done=%b set=%b rem=%0d line0=%b want 1 0 104 1", hit_done, hit_was_set, remaining, line[0]);
    end
  endtask

  task automatic test_reset_mid_hit();
    hit_valid = 1'b1;
    hit_row   = 4'd0;
    hit_col   = 4'd2;
    #2;
    nRst = 1'b0;
    model_init();
    @(posedge clk);
    #1;
    vectors++;
    if (hit_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_hit_in_reset: got %b want 0", hit_done);
    end
    hit_valid = 1'b0;
    nRst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (hit_done !== 1'b0 || remaining !== 8'd104 || line !== init_row(0)) begin
      miscompares++;
      $display("FAIL rst_hit_after: got done=%b rem=%0d line=%b want 0 104 %b", hit_done, remaining, line, init_row(0));
    end
  endtask

  initial begin
    test_reset();
    test_hit_basic();
    test_scan();
    test_out_of_range();
    test_random();
    test_clear_all();
    test_reload_hit();
    test_reset_mid_hit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
